// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter and sequencer for a shared 8:1 mux.
// Picks one of eight requesters, steers the mux select to it, and runs a
// valid/ready handshake toward the single downstream consumer. Locked bursts
// let one requester keep the grant for up to MAX_LOCK consecutive beats.
// No payload passes through this block.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   req_i[7:0]   per-requester request (bit i drives mux input i)
//   lock_i[7:0]  per-requester burst lock, only the granted bit is used
//   out_ready_i  consumer accepts the current mux output
//   sel_o[2:0]   mux select, binary index of the granted requester
//   grant_o[7:0] one-hot grant, zero when idle
//   out_valid_o  mux output valid toward the consumer
//   ack_o[7:0]   one-cycle pulse on bit i when requester i's beat is accepted

module mux8_rr_arbiter #(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_i,
    input  logic [7:0] lock_i,
    input  logic       out_ready_i,
    output logic [2:0] sel_o,
    output logic [7:0] grant_o,
    output logic       out_valid_o,
    output logic [7:0] ack_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e     state_q;
    logic [7:0] grant_q;
    logic [2:0] sel_q;
    logic       out_valid_q;
    logic [7:0] ack_q;
    logic [2:0] rr_ptr_q;
    logic [3:0] lock_cnt_q;

    // First requester at or after ptr, wrapping 7 -> 0. Result {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [2:0] nxt_ptr;
    logic       hold;
    logic       rearb;
    logic [3:0] pick;

    always_comb begin
        nxt_ptr = sel_q + 3'd1;
        // Locked burst continues only while under the fairness cap.
        hold    = out_ready_i & lock_i[sel_q] & req_i[sel_q] &
                  (lock_cnt_q < 4'(MAX_LOCK));
        rearb   = 1'b0;
        pick    = 4'b0;
        unique case (state_q)
            StIdle: begin
                rearb = 1'b1;
                pick  = rr_pick(req_i, rr_ptr_q);
            end
            StBusy: begin
                // Either an accepted beat that does not hold, or a withdrawn beat.
                rearb = out_ready_i ? ~hold : ~req_i[sel_q];
                // Current owner is scanned last, so it only wins if nobody else waits.
                pick  = rr_pick(req_i, nxt_ptr);
            end
            default: begin
                rearb = 1'b1;
                pick  = 4'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            grant_q     <= 8'h00;
            sel_q       <= 3'd0;
            out_valid_q <= 1'b0;
            ack_q       <= 8'h00;
            rr_ptr_q    <= 3'd0;
            lock_cnt_q  <= 4'd0;
        end else begin
            ack_q <= 8'h00;
            if (state_q == StBusy && out_ready_i) begin
                ack_q <= grant_q;
            end
            if (rearb) begin
                if (state_q == StBusy) begin
                    rr_ptr_q <= nxt_ptr;
                end
                if (pick[3]) begin
                    state_q     <= StBusy;
                    grant_q     <= 8'b1 << pick[2:0];
                    sel_q       <= pick[2:0];
                    out_valid_q <= 1'b1;
                    lock_cnt_q  <= 4'd1;
                end else begin
                    state_q     <= StIdle;
                    grant_q     <= 8'h00;
                    sel_q       <= 3'd0;
                    out_valid_q <= 1'b0;
                    lock_cnt_q  <= 4'd0;
                end
            end else if (hold) begin
                lock_cnt_q <= lock_cnt_q + 4'd1;
            end
        end
    end

    assign sel_o       = sel_q;
    assign grant_o     = grant_q;
    assign out_valid_o = out_valid_q;
    assign ack_o       = ack_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Testbench for mux8_rr_arbiter: directed scenarios plus a randomized run,
// each compared against a behavioural reference model of the arbiter.

module tb_mux8_rr_arbiter;

    localparam int MaxLock = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] lock = 8'h00;
    logic       rdy = 1'b0;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic [7:0] ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = idle), pointer, burst count, acked index.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_ack   = -1;

    bit         inv_en = 1'b0;
    logic [7:0] prev_grant = 8'h00;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(
        .MAX_LOCK(MaxLock)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .lock_i     (lock),
        .out_ready_i(rdy),
        .sel_o      (sel),
        .grant_o    (grant),
        .out_valid_o(valid),
        .ack_o      (ack)
    );

    function automatic int first_from(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic r, input logic [7:0] rq,
                                       input logic [7:0] lk, input logic rd);
        m_ack = -1;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            m_owner = first_from(rq, m_ptr);
            m_cnt   = (m_owner >= 0) ? 1 : 0;
        end else if (rd) begin
            m_ack = m_owner;
            if (lk[m_owner] && rq[m_owner] && m_cnt < MaxLock) begin
                m_cnt++;
            end else begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = first_from(rq, m_ptr);
                m_cnt   = (m_owner >= 0) ? 1 : 0;
            end
        end else if (!rq[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = first_from(rq, m_ptr);
            m_cnt   = (m_owner >= 0) ? 1 : 0;
        end
    endfunction

    // Expected {sel, grant, out_valid, ack} from the model.
    function automatic logic [19:0] exp_vec();
        logic [2:0] s;
        logic [7:0] g;
        logic [7:0] a;
        s = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        a = (m_ack >= 0) ? 8'(1 << m_ack) : 8'h00;
        return {s, g, (m_owner >= 0), a};
    endfunction

    task automatic cycle(input logic r, input logic [7:0] rq, input logic [7:0] lk,
                         input logic rd);
        rst  = r;
        req  = rq;
        lock = lk;
        rdy  = rd;
        @(posedge clk);
        model_step(r, rq, lk, rd);
        #1;
    endtask

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (inv_en) begin
            n_checks++;
            if (!$onehot0(grant)) begin
                n_fail++;
                $display("FAIL inv_grant_onehot: grant=%h", grant);
            end
            n_checks++;
            if (valid !== (grant != 8'h00)) begin
                n_fail++;
                $display("FAIL inv_valid: out_valid=%b grant=%h", valid, grant);
            end
            if (grant != 8'h00) begin
                n_checks++;
                if (grant !== 8'(1 << sel)) begin
                    n_fail++;
                    $display("FAIL inv_sel: sel=%0d grant=%h", sel, grant);
                end
            end
            n_checks++;
            if (!$onehot0(ack) || ((ack & ~prev_grant) != 8'h00)) begin
                n_fail++;
                $display("FAIL inv_ack: ack=%h prev_grant=%h", ack, prev_grant);
            end
        end
        prev_grant = grant;
    end

    task automatic test_reset();
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        inv_en = 1'b1;
        cycle(1'b0, 8'h08, 8'h00, 1'b0);
        cycle(1'b0, 8'h08, 8'h00, 1'b1);  // pointer moves past 3, 3 re-granted
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 8'h08, 8'h00, 1'b1);
            n_checks++;
            if ({sel, grant, valid, ack} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h want 00000", {sel, grant, valid, ack});
            end
        end
        cycle(1'b0, 8'hFF, 8'h00, 1'b0);
        n_checks++;
        if (sel !== 3'd0 || grant !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_ptr: sel=%0d grant=%h want sel=0 grant=01", sel, grant);
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        cycle(1'b0, 8'h04, 8'h00, 1'b1);
        n_checks++;
        if ({sel, grant, valid, ack} !== {3'd2, 8'h04, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL single_grant: got %h want %h", {sel, grant, valid, ack},
                     {3'd2, 8'h04, 1'b1, 8'h00});
        end
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++;
        if ({sel, grant, valid, ack} !== {3'd0, 8'h00, 1'b0, 8'h04}) begin
            n_fail++;
            $display("FAIL single_ack: got %h want %h", {sel, grant, valid, ack},
                     {3'd0, 8'h00, 1'b0, 8'h04});
        end
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        n_checks++;
        if ({sel, grant, valid, ack} !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_idle: got %h want %h", {sel, grant, valid, ack}, exp_vec());
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] want_ack;
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 8'hFF, 8'h00, 1'b1);
            want_ack = (k == 0) ? 8'h00 : 8'(1 << ((k - 1) % 8));
            n_checks++;
            if (sel !== 3'(k % 8) || valid !== 1'b1 || ack !== want_ack) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: sel=%0d valid=%b ack=%h want sel=%0d ack=%h",
                         k, sel, valid, ack, k % 8, want_ack);
            end
        end
    endtask

    task automatic test_stall();
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 8'h81, 8'h00, 1'b0);
            n_checks++;
            if (sel !== 3'd0 || valid !== 1'b1 || ack !== 8'h00) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: sel=%0d valid=%b ack=%h want 0/1/00",
                         k, sel, valid, ack);
            end
        end
        cycle(1'b0, 8'h81, 8'h00, 1'b1);
        n_checks++;
        if (ack !== 8'h01 || sel !== 3'd7) begin
            n_fail++;
            $display("FAIL stall_release: ack=%h sel=%0d want ack=01 sel=7", ack, sel);
        end
        cycle(1'b0, 8'h81, 8'h00, 1'b1);
        n_checks++;
        if ({sel, grant, valid, ack} !== exp_vec()) begin
            n_fail++;
            $display("FAIL stall_next: got %h want %h", {sel, grant, valid, ack}, exp_vec());
        end
    endtask

    task automatic test_lock_cap();
        logic [2:0] want_sel [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        logic [7:0] want_ack [6] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 8'h03, 8'h01, 1'b1);
            n_checks++;
            if (sel !== want_sel[k] || ack !== want_ack[k]) begin
                n_fail++;
                $display("FAIL lock_cap[%0d]: sel=%0d ack=%h want sel=%0d ack=%h",
                         k, sel, ack, want_sel[k], want_ack[k]);
            end
        end
    endtask

    task automatic test_withdraw();
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        cycle(1'b0, 8'h08, 8'h00, 1'b0);
        cycle(1'b0, 8'h08, 8'h00, 1'b0);
        // Requester 3 drops; 0 and 1 would win from pointer 0, so 5 proves the advance.
        cycle(1'b0, 8'h23, 8'h00, 1'b0);
        n_checks++;
        if (sel !== 3'd5 || grant !== 8'h20 || ack !== 8'h00) begin
            n_fail++;
            $display("FAIL withdraw: sel=%0d grant=%h ack=%h want 5/20/00", sel, grant, ack);
        end
        cycle(1'b0, 8'h23, 8'h00, 1'b1);
        n_checks++;
        if (ack !== 8'h20 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL withdraw_next: ack=%h sel=%0d want ack=20 sel=0", ack, sel);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        cycle(1'b0, 8'h40, 8'h00, 1'b0);
        cycle(1'b0, 8'h81, 8'h00, 1'b1);
        n_checks++;
        if (ack !== 8'h40 || sel !== 3'd7) begin
            n_fail++;
            $display("FAIL wrap_first: ack=%h sel=%0d want ack=40 sel=7", ack, sel);
        end
        cycle(1'b0, 8'h81, 8'h00, 1'b1);
        n_checks++;
        if (ack !== 8'h80 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_second: ack=%h sel=%0d want ack=80 sel=0", ack, sel);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic [7:0] rq;
        logic [7:0] lk;
        logic       rd;
        cycle(1'b1, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 60) == 0);
            rq = 8'($urandom) & 8'($urandom);
            lk = 8'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            cycle(r, rq, lk, rd);
            n_checks++;
            if ({sel, grant, valid, ack} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h (req=%h lock=%h rdy=%b)",
                         k, {sel, grant, valid, ack}, exp_vec(), rq, lk, rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_lock_cap();
        test_withdraw();
        test_wrap();
        test_random();
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
